// File: rtl/parity_buffer_ctrl.sv
// rtl/parity_buffer_ctrl.sv - parity buffer sequencer: one write pulse per batch, then ordered handshaked readout
module parity_buffer_ctrl #(
    parameter int MUL_SH_BLOCKS_COUNT = 23,
    parameter int CNT_W               = $clog2(MUL_SH_BLOCKS_COUNT + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] parity_count,
    input  logic             flush,
    output logic             buf_wr_en,
    output logic             buf_rd_en,
    output logic [8:0]       buf_rd_address,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_index,
    output logic             out_last,
    output logic             busy,
    output logic             cfg_err
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MUL_SH_BLOCKS_COUNT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rd_idx_q, rd_idx_d;
    logic             wr_en_q, wr_en_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] out_index_q, out_index_d;
    logic             out_last_q, out_last_d;
    logic             cfg_err_q, cfg_err_d;
    logic             count_ok;
    logic             rd_last;

    // A read is only issued when the output slot is free or being emptied this cycle.
    assign buf_rd_en      = (state_q == READ) && (!out_valid_q || out_ready) && !flush;
    assign in_ready       = (state_q == IDLE) && !flush;
    assign busy           = (state_q != IDLE);
    assign buf_wr_en      = wr_en_q;
    assign buf_rd_address = {{(9 - CNT_W){1'b0}}, rd_idx_q};
    assign out_valid      = out_valid_q;
    assign out_index      = out_index_q;
    assign out_last       = out_last_q;
    assign cfg_err        = cfg_err_q;

    assign count_ok = (parity_count != '0) && (parity_count <= MAX_CNT);
    assign rd_last  = (rd_idx_q == cnt_q - ONE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_idx_d    = rd_idx_q;
        wr_en_d     = 1'b0;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        cfg_err_d   = 1'b0;
        if (flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            rd_idx_d    = '0;
            out_valid_d = 1'b0;
        end else begin
            if (buf_rd_en) begin
                out_valid_d = 1'b1;
                out_index_d = rd_idx_q;
                out_last_d  = rd_last;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (count_ok) begin
                            cnt_d   = parity_count;
                            wr_en_d = 1'b1;
                            state_d = WRITE;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    rd_idx_d = '0;
                    state_d  = READ;
                end
                READ: begin
                    if (buf_rd_en) begin
                        rd_idx_d = rd_idx_q + ONE;
                        if (rd_last) state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_valid_q && out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rd_idx_q    <= '0;
            wr_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_idx_q    <= rd_idx_d;
            wr_en_q     <= wr_en_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    a_wr_rd_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(buf_wr_en && buf_rd_en));

endmodule

// File: tb/tb_parity_buffer_ctrl.sv
// tb/tb_parity_buffer_ctrl.sv - self-checking bench for parity_buffer_ctrl
module tb_parity_buffer_ctrl;

    localparam int NMAX  = 23;
    localparam int CNT_W = $clog2(NMAX + 1);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [CNT_W-1:0] parity_count;
    logic             flush;
    logic             buf_wr_en;
    logic             buf_rd_en;
    logic [8:0]       buf_rd_address;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_index;
    logic             out_last;
    logic             busy;
    logic             cfg_err;

    int total = 0;
    int bad   = 0;
    int rdy_mode = 1;

    // Transaction-level model state
    logic active = 1'b0;
    logic exp_wr = 1'b0;
    logic exp_cfg = 1'b0;
    logic exp_in_ready;
    int   exp_n = 0;
    int   exp_next = 0;
    int   acc_cnt = 0;
    logic prev_stall = 1'b0;
    int   prev_idx = 0;
    int   prev_addr = 0;

    parity_buffer_ctrl #(.MUL_SH_BLOCKS_COUNT(NMAX)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .parity_count(parity_count), .flush(flush), .buf_wr_en(buf_wr_en),
        .buf_rd_en(buf_rd_en), .buf_rd_address(buf_rd_address), .out_valid(out_valid),
        .out_ready(out_ready), .out_index(out_index), .out_last(out_last),
        .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Per-cycle compare against the batch-level model
    always @(negedge clk) begin
        if (!reset_n) begin
            active = 1'b0; exp_wr = 1'b0; exp_cfg = 1'b0; prev_stall = 1'b0;
        end else begin
            exp_in_ready = !active && !flush;
            check("in_ready", in_ready, exp_in_ready);
            check("busy", busy, active);
            check("wr_en", buf_wr_en, exp_wr);
            check("cfg_err", cfg_err, exp_cfg);
            check("wr_rd_excl", buf_wr_en & buf_rd_en, 0);
            if (out_valid && !out_ready) check("rd_in_stall", buf_rd_en, 0);
            if (flush) check("rd_in_flush", buf_rd_en, 0);
            if (!active) begin
                check("valid_idle", out_valid, 0);
                check("rd_idle", buf_rd_en, 0);
            end
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_idx", out_index, prev_idx);
                check("stall_addr", buf_rd_address, prev_addr);
            end
            if (active && out_valid) begin
                check("idx", out_index, exp_next);
                check("last", out_last, exp_next == exp_n - 1);
            end
            exp_wr = 1'b0;
            exp_cfg = 1'b0;
            prev_stall = out_valid && !out_ready && !flush;
            prev_idx = out_index;
            prev_addr = buf_rd_address;
            if (flush) begin
                active = 1'b0;
            end else begin
                if (active && out_valid && out_ready) begin
                    exp_next++;
                    acc_cnt++;
                    if (exp_next == exp_n) active = 1'b0;
                end else if (in_valid && exp_in_ready) begin
                    if (parity_count >= 1 && parity_count <= NMAX) begin
                        active = 1'b1; exp_n = parity_count; exp_next = 0;
                        acc_cnt = 0; exp_wr = 1'b1;
                    end else begin
                        exp_cfg = 1'b1;
                    end
                end
            end
        end
    end

    // Returns in cycle T0+1 (just after the handshake edge T0)
    task automatic start_batch(input int n);
        @(posedge clk); #1;
        in_valid = 1'b1;
        parity_count = CNT_W'(n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        parity_count = CNT_W'(7);
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (active && k < 2000) begin
            @(negedge clk); #1;
            k++;
        end
        check("done_timeout", active, 0);
        check("delivered", acc_cnt, n);
    endtask

    task automatic basic_timed(input int n);
        rdy_mode = 1;
        start_batch(n);
        @(negedge clk);
        check("t1_wr", buf_wr_en, 1);
        check("t1_rd", buf_rd_en, 0);
        @(negedge clk);
        check("t2_rd", buf_rd_en, 1);
        check("t2_addr", buf_rd_address, 0);
        check("t2_valid", out_valid, 0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("tk_valid", out_valid, 1);
            check("tk_idx", out_index, k);
            check("tk_last", out_last, k == n - 1);
            if (k + 1 < n) begin
                check("tk_rd", buf_rd_en, 1);
                check("tk_addr", buf_rd_address, k + 1);
            end
        end
        @(negedge clk);
        check("tend_in_ready", in_ready, 1);
        check("tend_valid", out_valid, 0);
    endtask

    task automatic bad_count(input int c);
        rdy_mode = 1;
        start_batch(c);
        @(negedge clk);
        check("bad_cfg1", cfg_err, 1);
        check("bad_in_ready", in_ready, 1);
        check("bad_wr", buf_wr_en, 0);
        @(negedge clk);
        check("bad_cfg2", cfg_err, 0);
        check("bad_busy", busy, 0);
        check("bad_rd", buf_rd_en, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_wr"}, buf_wr_en, 0);
        check({tag, "_addr"}, buf_rd_address, 0);
        check({tag, "_idx"}, out_index, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_cfg"}, cfg_err, 0);
    endtask

    initial begin
        logic found;
        reset_n = 1'b0; in_valid = 1'b0; parity_count = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset_n = 1'b1;

        basic_timed(23);
        basic_timed(1);

        rdy_mode = 2;
        start_batch(10);
        wait_done(10);
        rdy_mode = 1;

        bad_count(0);
        bad_count(24);

        start_batch(12);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk); #1;
            if (busy && buf_rd_address == 9'd5) found = 1'b1;
        end
        check("flush_reach", found, 1);
        flush = 1'b1;
        @(negedge clk);
        check("flush_rd", buf_rd_en, 0);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("postflush_valid", out_valid, 0);
        check("postflush_in_ready", in_ready, 1);
        basic_timed(3);

        rdy_mode = 0;
        start_batch(1);
        repeat (3) @(negedge clk);
        check("drain_valid", out_valid, 1);
        check("drain_last", out_last, 1);
        check("drain_busy", busy, 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        basic_timed(23);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

endmodule
